// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin sharing of one memory port between two
// masters. One transaction is outstanding at a time, and its downstream
// fields are held in registers. A watchdog ends any transaction whose
// acknowledge never arrives.
module cache_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_done,
   output logic              r0_err,
   output logic [DATA_W-1:0] r0_rdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_done,
   output logic              r1_err,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_ack,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   // The counter holds the number of ISSUE cycles already spent, so the
   // abort fires in the TIMEOUT-th ISSUE cycle.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state;
   logic [7:0]        cnt;
   logic              grant;
   logic              resp_err;
   logic [DATA_W-1:0] resp_data;

   // Round-robin pick: on a tie, the requester that did not go last wins.
   always_comb begin
      grant = 1'b0;
      if (r0_req && r1_req) begin
         grant = ~owner;
      end else if (r1_req) begin
         grant = 1'b1;
      end
   end

   // Response for the current ISSUE cycle. A write or a timeout returns zero data.
   always_comb begin
      resp_err  = ~m_ack;
      resp_data = '0;
      if (m_ack && !m_we) begin
         resp_data = m_rdata;
      end
   end

   // Sequencer: grant, hold the downstream request, then pulse done to the owner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b1;
         cnt      <= '0;
         busy     <= 1'b0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
         r0_done  <= 1'b0;
         r1_done  <= 1'b0;
         r0_err   <= 1'b0;
         r1_err   <= 1'b0;
         r0_rdata <= '0;
         r1_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (r0_req || r1_req) begin
                  owner   <= grant;
                  m_we    <= grant ? r1_we    : r0_we;
                  m_addr  <= grant ? r1_addr  : r0_addr;
                  m_wdata <= grant ? r1_wdata : r0_wdata;
                  m_req   <= 1'b1;
                  busy    <= 1'b1;
                  cnt     <= '0;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ack || (cnt == CNT_LAST)) begin
                  m_req <= 1'b0;
                  state <= DONE;
                  if (owner) begin
                     r1_done  <= 1'b1;
                     r1_err   <= resp_err;
                     r1_rdata <= resp_data;
                  end else begin
                     r0_done  <= 1'b1;
                     r0_err   <= resp_err;
                     r0_rdata <= resp_data;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DONE: begin
               r0_done <= 1'b0;
               r1_done <= 1'b0;
               r0_err  <= 1'b0;
               r1_err  <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               m_req <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester round-robin arbiter and transaction sequencer that shares one memory port between two independent masters, for example an instruction fetch path and a data path. It sits between the masters and the `cache_and_ram` memory subsystem's request/acknowledge port. It allows one outstanding transaction, registers and holds all downstream fields, and returns read data to the granted master. A watchdog terminates any transaction whose acknowledge does not arrive within a bounded number of cycles.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles in ISSUE before abort (1..255)
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `r0_req`, `r1_req`  in  1  request valid, held until matching done
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read
- `r0_addr`, `r1_addr`  in  ADDR_W  request address
- `r0_wdata`, `r1_wdata`  in  DATA_W  write data
- `r0_done`, `r1_done`  out  1  one-cycle completion pulse
- `r0_err`, `r1_err`  out  1  valid with done; 1 = timed out
- `r0_rdata`, `r1_rdata`  out  DATA_W  read data, valid with done
- `m_req`  out  1  downstream request, held until ack or timeout
- `m_we`  out  1  downstream write enable
- `m_addr`  out  ADDR_W  downstream address
- `m_wdata`  out  DATA_W  downstream write data
- `m_ack`  in  1  downstream completion, one cycle
- `m_rdata`  in  DATA_W  downstream read data, valid with `m_ack`
- `busy`  out  1  state != IDLE
- `owner`  out  1  index of the current or last granted requester

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE:
  - If any `rN_req` is high, grant one requester, latch its `we`, `addr` and `wdata` into the `m_*` registers, set `owner`, clear the timeout counter, and go to ISSUE.
  - If no request is high, stay in IDLE.
- Round-robin arbitration:
  - When both requests are high, the requester that is not `owner` wins.
  - When one request is high, it wins.
  - `owner` resets to 1, so r0 wins the first tie.
- ISSUE:
  - `m_req` is high and `m_*` fields are stable.
  - On `m_ack`: capture `m_rdata` (read) or 0 (write) into the owner's `rdata`, set err = 0, and go to DONE.
  - Otherwise the counter increments. When the counter equals `TIMEOUT - 1` and `m_ack` is low, set rdata = 0, set err = 1, and go to DONE.
- DONE:
  - `r[owner]_done` is high for exactly one cycle, then the block returns to IDLE.
  - The non-owner's done, err and rdata stay 0.
- Requester rule: `rN_req` and its fields stay stable from assertion until done is sampled high. The requester drops `req` on the edge where it samples done. A request still high in the following IDLE cycle is treated as a new request.
- `m_ack` is ignored outside ISSUE.
- `rN_rdata` holds its last value between transactions. `err` is only meaningful with done.
- A write returns done with rdata = 0. Cache coherence is not this block's concern; write-through is handled downstream.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - state = IDLE, `owner` = 1, counter = 0
  - `m_req`, `m_we`, `busy`, all `done` and all `err` = 0
  - `m_addr`, `m_wdata`, all `rdata` = 0
- `m_req` drops within the same cycle that reset asserts.
- Reset mid-transaction aborts the transaction with no done pulse.
- Latency with request high in cycle 0:
  - `m_req` is high from cycle 1.
  - With `m_ack` in cycle k ≥ 1, done is high in cycle k+1.
  - Back-to-back: the next `m_req` rises in cycle k+3 (the IDLE cycle is k+2).
- Timeout: with no ack, `m_req` is high for exactly `TIMEOUT` cycles (cycles 1..TIMEOUT), and done with err = 1 is high in cycle TIMEOUT+1.
- `m_ack` in the last allowed cycle: the ack wins and err = 0.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Single read: r0 issues a read of addr 0x10, `m_ack` arrives 3 cycles later with `m_rdata` = 0xDEADBEEF. Required: `r0_done` for one cycle with `r0_rdata` = 0xDEADBEEF and `r0_err` = 0; r1 outputs stay 0.
- Tie after reset: r0 and r1 request together. Required: r0 is granted first (`owner` = 0), then r1 is granted 3 cycles after r0's ack.
- Fairness: both requesters hold continuous requests for 6 transactions with immediate ack. Required: grant sequence r0, r1, r0, r1, r0, r1.
- Write: r1 writes 0x55AA to addr 0x20. Required: `m_we` = 1, `m_addr` = 0x20 and `m_wdata` = 0x55AA stable for the whole of ISSUE; `r1_rdata` = 0 with `r1_done`.
- Timeout with `TIMEOUT` = 4 and no ack. Required: `m_req` is high for exactly 4 cycles, then done with err = 1 and rdata = 0. Repeat with ack in the 4th cycle: err = 0.
- Reset pulse in cycle 2 of ISSUE. Required: `m_req` drops immediately, no done pulse occurs, and after release `owner` = 1 and the block is in IDLE.
